// File: rtl/rv_chk_pkg.sv
// Shared types and address-map constants for the RV32I datapath checker.
// Imported by the checker top and by its ALU golden model.
package rv_chk_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // Data memory is 8 KiB; its base is a parameter of the checker top.
  localparam logic [31:0] DMEM_SIZE  = 32'h0000_2000;

  localparam logic [31:0] LEDR_BASE  = 32'h0000_7000;
  localparam logic [31:0] LEDR_LIM   = 32'h0000_700F;
  localparam logic [31:0] LEDG_BASE  = 32'h0000_7010;
  localparam logic [31:0] LEDG_LIM   = 32'h0000_701F;
  localparam logic [31:0] SEG7_BASE  = 32'h0000_7020;
  localparam logic [31:0] SEG7_LIM   = 32'h0000_702F;
  localparam logic [31:0] LCD_BASE   = 32'h0000_7030;
  localparam logic [31:0] LCD_LIM    = 32'h0000_703F;
  localparam logic [31:0] SW_BASE    = 32'h0000_7800;
  localparam logic [31:0] SW_LIM     = 32'h0000_780F;
  localparam logic [31:0] BTN_BASE   = 32'h0000_7810;
  localparam logic [31:0] BTN_LIM    = 32'h0000_781F;
  localparam logic [31:0] TIMER_BASE = 32'h0000_7820;
  localparam logic [31:0] TIMER_LIM  = 32'h0000_782F;

  typedef struct packed {
    logic data_mem;
    logic ledr;
    logic ledg;
    logic seg7;
    logic lcd;
    logic sw;
    logic btn;
    logic timer;
  } lsu_vld_t;

  function automatic logic in_rng(input logic [31:0] addr,
                                  input logic [31:0] base,
                                  input logic [31:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/rv_chk_alu_model.sv
// Combinational golden ALU; chk_en is low for opcodes the core never issues.
module rv_chk_alu_model
  import rv_chk_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] exp,
  output logic        chk_en
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    exp    = 32'h0;
    chk_en = 1'b1;
    case (op)
      ALU_ADD:  exp = a + b;
      ALU_SUB:  exp = a - b;
      ALU_SLT:  exp = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: exp = {31'b0, (a < b)};
      ALU_XOR:  exp = a ^ b;
      ALU_OR:   exp = a | b;
      ALU_AND:  exp = a & b;
      ALU_SLL:  exp = a << shamt;
      ALU_SRL:  exp = a >> shamt;
      ALU_SRA:  exp = 32'($signed(a) >>> shamt);
      ALU_LUI:  exp = b;
      default:  chk_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_datapath_checker.sv
// Observational monitor for the single-cycle RV32I core: ALU, branch comparator
// and LSU decode are compared to golden models; mismatches pulse and are counted.
module rv_datapath_checker
  import rv_chk_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] DMEM_BASE = 32'h0000_2000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      drv_operand_a,
  input  logic [31:0]      drv_operand_b,
  input  logic [3:0]       drv_alu_op,
  input  logic [31:0]      act_alu_res,
  input  logic [31:0]      drv_rs1_data,
  input  logic [31:0]      drv_rs2_data,
  input  logic             drv_br_un,
  input  logic             act_br_eq,
  input  logic             act_br_lt,
  input  logic             drv_VALID,
  input  logic [31:0]      drv_lsu_addr,
  input  logic             act_vld_data_mem,
  input  logic             act_vld_ledr,
  input  logic             act_vld_ledg,
  input  logic             act_vld_seg7,
  input  logic             act_vld_lcd,
  input  logic             act_vld_sw,
  input  logic             act_vld_btn,
  input  logic             act_vld_timer,
  output logic             o_alu_err,
  output logic             o_br_err,
  output logic             o_lsu_err,
  output logic [CNT_W-1:0] o_alu_err_cnt,
  output logic [CNT_W-1:0] o_br_err_cnt,
  output logic [CNT_W-1:0] o_lsu_err_cnt,
  output logic [31:0]      o_chk_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      DMEM_LIM = DMEM_BASE + DMEM_SIZE - 32'd1;

  logic [31:0] exp_alu;
  logic        alu_chk_en;
  logic        exp_eq;
  logic        exp_lt;
  lsu_vld_t    exp_vld;
  lsu_vld_t    act_vld;
  logic        alu_mis;
  logic        br_mis;
  logic        lsu_mis;

  rv_chk_alu_model u_alu_model (
    .op     (drv_alu_op),
    .a      (drv_operand_a),
    .b      (drv_operand_b),
    .exp    (exp_alu),
    .chk_en (alu_chk_en)
  );

  assign exp_eq = (drv_rs1_data == drv_rs2_data);
  assign exp_lt = drv_br_un ? (drv_rs1_data < drv_rs2_data)
                            : ($signed(drv_rs1_data) < $signed(drv_rs2_data));

  assign act_vld = {act_vld_data_mem, act_vld_ledr, act_vld_ledg, act_vld_seg7,
                    act_vld_lcd, act_vld_sw, act_vld_btn, act_vld_timer};

  // Anything above 64 KiB is unmapped, and a quiet LSU must decode to nothing.
  always_comb begin
    exp_vld = '0;
    if (drv_VALID && (drv_lsu_addr[31:16] == 16'h0)) begin
      exp_vld.data_mem = in_rng(drv_lsu_addr, DMEM_BASE, DMEM_LIM);
      exp_vld.ledr     = in_rng(drv_lsu_addr, LEDR_BASE, LEDR_LIM);
      exp_vld.ledg     = in_rng(drv_lsu_addr, LEDG_BASE, LEDG_LIM);
      exp_vld.seg7     = in_rng(drv_lsu_addr, SEG7_BASE, SEG7_LIM);
      exp_vld.lcd      = in_rng(drv_lsu_addr, LCD_BASE, LCD_LIM);
      exp_vld.sw       = in_rng(drv_lsu_addr, SW_BASE, SW_LIM);
      exp_vld.btn      = in_rng(drv_lsu_addr, BTN_BASE, BTN_LIM);
      exp_vld.timer    = in_rng(drv_lsu_addr, TIMER_BASE, TIMER_LIM);
    end
  end

  assign alu_mis = alu_chk_en && (act_alu_res != exp_alu);
  assign br_mis  = (act_br_eq != exp_eq) || (act_br_lt != exp_lt);
  assign lsu_mis = (act_vld != exp_vld);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_alu_err     <= 1'b0;
      o_br_err      <= 1'b0;
      o_lsu_err     <= 1'b0;
      o_alu_err_cnt <= '0;
      o_br_err_cnt  <= '0;
      o_lsu_err_cnt <= '0;
      o_chk_cnt     <= 32'h0;
    end else begin
      o_alu_err <= alu_mis;
      o_br_err  <= br_mis;
      o_lsu_err <= lsu_mis;
      if (alu_mis && (o_alu_err_cnt != CNT_MAX)) o_alu_err_cnt <= o_alu_err_cnt + CNT_ONE;
      if (br_mis && (o_br_err_cnt != CNT_MAX))   o_br_err_cnt  <= o_br_err_cnt + CNT_ONE;
      if (lsu_mis && (o_lsu_err_cnt != CNT_MAX)) o_lsu_err_cnt <= o_lsu_err_cnt + CNT_ONE;
      o_chk_cnt <= o_chk_cnt + 32'd1;
    end
  end

`ifdef RV_CHK_REPORT
  // Simulation-only diagnostics; define RV_CHK_REPORT to enable them.
  always_ff @(posedge i_clk) begin
    if (!i_rst && alu_mis)
      $error("%0t alu op=%0d exp=%h act=%h", $time, drv_alu_op, exp_alu, act_alu_res);
    if (!i_rst && br_mis)
      $error("%0t br exp eq/lt=%b%b act=%b%b", $time, exp_eq, exp_lt, act_br_eq, act_br_lt);
    if (!i_rst && lsu_mis)
      $error("%0t lsu addr=%h exp=%b act=%b", $time, drv_lsu_addr, exp_vld, act_vld);
  end
`endif

endmodule

// File: tb/tb_rv_datapath_checker.sv
// Directed, table-driven bench for rv_datapath_checker with hand-computed expectations,
// plus reset-discard and counter-saturation sequences.
module tb_rv_datapath_checker;

  localparam int CNT_W = 16;

  logic             i_clk;
  logic             i_rst;
  logic [31:0]      drv_operand_a;
  logic [31:0]      drv_operand_b;
  logic [3:0]       drv_alu_op;
  logic [31:0]      act_alu_res;
  logic [31:0]      drv_rs1_data;
  logic [31:0]      drv_rs2_data;
  logic             drv_br_un;
  logic             act_br_eq;
  logic             act_br_lt;
  logic             drv_VALID;
  logic [31:0]      drv_lsu_addr;
  logic [7:0]       act_vld;
  logic             o_alu_err;
  logic             o_br_err;
  logic             o_lsu_err;
  logic [CNT_W-1:0] o_alu_err_cnt;
  logic [CNT_W-1:0] o_br_err_cnt;
  logic [CNT_W-1:0] o_lsu_err_cnt;
  logic [31:0]      o_chk_cnt;

  int vectors;
  int miscompares;

  // Bench-side expected counter state, advanced from the table's expected flags.
  int exp_alu_cnt;
  int exp_br_cnt;
  int exp_lsu_cnt;
  int exp_chk_cnt;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_act;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        br_un;
    logic        eq_act;
    logic        lt_act;
    logic        valid;
    logic [31:0] addr;
    logic [7:0]  vld_act;
    logic        exp_alu;
    logic        exp_br;
    logic        exp_lsu;
  } vec_t;

  vec_t vecs[$];

  rv_datapath_checker #(.CNT_W(CNT_W), .DMEM_BASE(32'h0000_2000)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .drv_operand_a    (drv_operand_a),
    .drv_operand_b    (drv_operand_b),
    .drv_alu_op       (drv_alu_op),
    .act_alu_res      (act_alu_res),
    .drv_rs1_data     (drv_rs1_data),
    .drv_rs2_data     (drv_rs2_data),
    .drv_br_un        (drv_br_un),
    .act_br_eq        (act_br_eq),
    .act_br_lt        (act_br_lt),
    .drv_VALID        (drv_VALID),
    .drv_lsu_addr     (drv_lsu_addr),
    .act_vld_data_mem (act_vld[7]),
    .act_vld_ledr     (act_vld[6]),
    .act_vld_ledg     (act_vld[5]),
    .act_vld_seg7     (act_vld[4]),
    .act_vld_lcd      (act_vld[3]),
    .act_vld_sw       (act_vld[2]),
    .act_vld_btn      (act_vld[1]),
    .act_vld_timer    (act_vld[0]),
    .o_alu_err        (o_alu_err),
    .o_br_err         (o_br_err),
    .o_lsu_err        (o_lsu_err),
    .o_alu_err_cnt    (o_alu_err_cnt),
    .o_br_err_cnt     (o_br_err_cnt),
    .o_lsu_err_cnt    (o_lsu_err_cnt),
    .o_chk_cnt        (o_chk_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // A quiet vector: correct ADD 0+0, equal comparator inputs, LSU idle.
  function automatic vec_t quiet(input string name);
    vec_t v;
    v.name = name;
    v.op = 4'd0; v.a = 32'h0; v.b = 32'h0; v.alu_act = 32'h0;
    v.rs1 = 32'h0; v.rs2 = 32'h0; v.br_un = 1'b0; v.eq_act = 1'b1; v.lt_act = 1'b0;
    v.valid = 1'b0; v.addr = 32'h0; v.vld_act = 8'h00;
    v.exp_alu = 1'b0; v.exp_br = 1'b0; v.exp_lsu = 1'b0;
    return v;
  endfunction

  function automatic vec_t alu_v(input string name, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] act, input logic e);
    vec_t v = quiet(name);
    v.op = op; v.a = a; v.b = b; v.alu_act = act; v.exp_alu = e;
    return v;
  endfunction

  function automatic vec_t br_v(input string name, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic un,
                                input logic eq, input logic lt, input logic e);
    vec_t v = quiet(name);
    v.rs1 = rs1; v.rs2 = rs2; v.br_un = un; v.eq_act = eq; v.lt_act = lt; v.exp_br = e;
    return v;
  endfunction

  function automatic vec_t lsu_v(input string name, input logic valid,
                                 input logic [31:0] addr, input logic [7:0] act,
                                 input logic e);
    vec_t v = quiet(name);
    v.valid = valid; v.addr = addr; v.vld_act = act; v.exp_lsu = e;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    drv_alu_op    = v.op;
    drv_operand_a = v.a;
    drv_operand_b = v.b;
    act_alu_res   = v.alu_act;
    drv_rs1_data  = v.rs1;
    drv_rs2_data  = v.rs2;
    drv_br_un     = v.br_un;
    act_br_eq     = v.eq_act;
    act_br_lt     = v.lt_act;
    drv_VALID     = v.valid;
    drv_lsu_addr  = v.addr;
    act_vld       = v.vld_act;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkCounters(input string name);
    checkOutput({name, " alu_cnt"}, 32'(o_alu_err_cnt), exp_alu_cnt);
    checkOutput({name, " br_cnt"},  32'(o_br_err_cnt),  exp_br_cnt);
    checkOutput({name, " lsu_cnt"}, 32'(o_lsu_err_cnt), exp_lsu_cnt);
    checkOutput({name, " chk_cnt"}, o_chk_cnt, exp_chk_cnt);
  endtask

  initial begin
    vec_t v;
    vectors = 0;
    miscompares = 0;

    vecs.push_back(alu_v("add_ovf_ok",   4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0));
    vecs.push_back(alu_v("add_ovf_bad",  4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0001, 1'b1));
    vecs.push_back(alu_v("sub",          4'd1, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0));
    vecs.push_back(alu_v("slt_neg",      4'd2, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0));
    vecs.push_back(alu_v("sltu_bad",     4'd3, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1));
    vecs.push_back(alu_v("xor",          4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0));
    vecs.push_back(alu_v("or",           4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0));
    vecs.push_back(alu_v("and",          4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0));
    vecs.push_back(alu_v("sra",          4'd9, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0));
    vecs.push_back(alu_v("srl",          4'd8, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0));
    vecs.push_back(alu_v("sll",          4'd7, 32'h8000_0000, 32'h21, 32'h0000_0000, 1'b0));
    vecs.push_back(alu_v("sll_bad",      4'd7, 32'h8000_0000, 32'h21, 32'h0000_0001, 1'b1));
    vecs.push_back(alu_v("lui",          4'd10, 32'hDEAD_0000, 32'h1234_5000, 32'h1234_5000, 1'b0));
    vecs.push_back(alu_v("op12_ignored", 4'd12, 32'h1, 32'h2, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(br_v("br_signed",     32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(br_v("br_unsigned",   32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(br_v("br_lt_bad",     32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b1, 1'b1));
    vecs.push_back(br_v("br_eq_bad",     32'h5, 32'h5, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(lsu_v("lsu_seg7",     1'b1, 32'h0000_7024, 8'h10, 1'b0));
    vecs.push_back(lsu_v("lsu_btn_bad",  1'b1, 32'h0000_7810, 8'h40, 1'b1));
    vecs.push_back(lsu_v("lsu_unmapped", 1'b1, 32'h2000_2000, 8'h00, 1'b0));
    vecs.push_back(lsu_v("lsu_gated",    1'b0, 32'h0000_2004, 8'h80, 1'b1));
    vecs.push_back(lsu_v("lsu_dmem_lo",  1'b1, 32'h0000_2000, 8'h80, 1'b0));
    vecs.push_back(lsu_v("lsu_dmem_hi",  1'b1, 32'h0000_3FFF, 8'h80, 1'b0));
    vecs.push_back(lsu_v("lsu_below",    1'b1, 32'h0000_1FFF, 8'h80, 1'b1));
    vecs.push_back(lsu_v("lsu_above",    1'b1, 32'h0000_4000, 8'h00, 1'b0));
    vecs.push_back(lsu_v("lsu_seg7_top", 1'b1, 32'h0000_702F, 8'h10, 1'b0));
    vecs.push_back(lsu_v("lsu_lcd",      1'b1, 32'h0000_7030, 8'h08, 1'b0));
    vecs.push_back(lsu_v("lsu_timer",    1'b1, 32'h0000_782F, 8'h01, 1'b0));
    vecs.push_back(lsu_v("lsu_gap",      1'b1, 32'h0000_7830, 8'h00, 1'b0));
    v = alu_v("all_three", 4'd0, 32'h1, 32'h1, 32'h3, 1'b1);
    v.rs1 = 32'h1; v.rs2 = 32'h2; v.eq_act = 1'b0; v.lt_act = 1'b0; v.exp_br = 1'b1;
    v.valid = 1'b1; v.addr = 32'h0000_7000; v.vld_act = 8'h00; v.exp_lsu = 1'b1;
    vecs.push_back(v);

    // Reset with mismatches present: they must be discarded.
    v = vecs[vecs.size()-1];
    applyStimulus(v);
    i_rst = 1'b1;
    tick();
    tick();
    checkOutput("rst alu_err", 32'(o_alu_err), 32'h0);
    checkOutput("rst br_err",  32'(o_br_err),  32'h0);
    checkOutput("rst lsu_err", 32'(o_lsu_err), 32'h0);
    exp_alu_cnt = 0; exp_br_cnt = 0; exp_lsu_cnt = 0; exp_chk_cnt = 0;
    checkCounters("rst");

    i_rst = 1'b0;
    applyStimulus(quiet("idle"));
    tick();
    exp_chk_cnt = 1;
    checkOutput("post_rst alu_err", 32'(o_alu_err), 32'h0);
    checkCounters("post_rst");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      tick();
      exp_chk_cnt++;
      if (vecs[i].exp_alu) exp_alu_cnt++;
      if (vecs[i].exp_br)  exp_br_cnt++;
      if (vecs[i].exp_lsu) exp_lsu_cnt++;
      checkOutput({vecs[i].name, " alu_err"}, 32'(o_alu_err), 32'(vecs[i].exp_alu));
      checkOutput({vecs[i].name, " br_err"},  32'(o_br_err),  32'(vecs[i].exp_br));
      checkOutput({vecs[i].name, " lsu_err"}, 32'(o_lsu_err), 32'(vecs[i].exp_lsu));
      checkCounters(vecs[i].name);
    end

    // Persistent ALU error long enough to saturate the counter.
    applyStimulus(alu_v("sat", 4'd0, 32'h1, 32'h1, 32'h0, 1'b1));
    repeat ((1 << CNT_W) + 5) begin
      tick();
      exp_chk_cnt++;
    end
    exp_alu_cnt = (1 << CNT_W) - 1;
    checkOutput("sat alu_err", 32'(o_alu_err), 32'h1);
    checkCounters("sat");

    // One reset cycle with the error still present, then restart.
    i_rst = 1'b1;
    tick();
    exp_alu_cnt = 0; exp_br_cnt = 0; exp_lsu_cnt = 0; exp_chk_cnt = 0;
    checkOutput("rst2 alu_err", 32'(o_alu_err), 32'h0);
    checkCounters("rst2");
    i_rst = 1'b0;
    applyStimulus(quiet("idle"));
    tick();
    exp_chk_cnt = 1;
    checkOutput("rst2_rel alu_err", 32'(o_alu_err), 32'h0);
    checkCounters("rst2_rel");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
